// File: rtl/seq_divider16.sv
// seq_divider16: iterative restoring divider, one quotient bit per cycle.
// Accepts signed or unsigned operands on a start pulse, flags divide-by-zero
// and signed overflow (most-negative / -1).
// Optional build macro DIV_EARLY_EXIT_EN: when the dividend magnitude is
// below the divisor magnitude the iterations are skipped (short path).
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overF
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's complement negation.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; 0x8000 maps to 0x8000 read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;       // partial remainder, one guard bit
  logic [WIDTH-1:0] q_q, q_d;           // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             hold_q, hold_d;     // short path stages its result one cycle
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             early_exit;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] trial;

  assign dvd_mag = magnitude(dividend, sign);
  assign dvs_mag = magnitude(divisor, sign);

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (dvd_mag < dvs_mag);
`else
  assign early_exit = 1'b0;
`endif

  assign rem_shift = {rem_q, q_q[WIDTH-1]};
  assign trial     = rem_shift - {2'b00, dvs_q};

  // Next-state, datapath and output computation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dz_d   = (divisor == ZERO);
          ovf_d  = sign & (dividend == MOST_NEG) & (divisor == ALL_ONES);
          dvs_d  = dvs_mag;
          if (divisor == ZERO) begin
            q_d     = ALL_ONES;
            rem_d   = {1'b0, dividend};
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            hold_d  = 1'b1;
            state_d = S_FIX;
          end else if (early_exit) begin
            q_d     = ZERO;
            rem_d   = {1'b0, dividend};
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            hold_d  = 1'b1;
            state_d = S_FIX;
          end else begin
            q_d     = dvd_mag;
            rem_d   = {(WIDTH+1){1'b0}};
            qneg_d  = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d  = sign & dividend[WIDTH-1];
            hold_d  = 1'b0;
            count_d = CW'(WIDTH);
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          quot_d  = qneg_q ? negate(q_q) : q_q;
          remo_d  = rneg_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= {CW{1'b0}};
      rem_q   <= {(WIDTH+1){1'b0}};
      q_q     <= ZERO;
      dvs_q   <= ZERO;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= ZERO;
      remo_q  <= ZERO;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dz_q;
  assign overF       = ovf_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed cases, control corners and
// randomized operations against an integer-arithmetic reference model.
module tb_seq_divider16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overF;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overF(overF)
  );

  always #5 clk = ~clk;

  // Directed table: dividend, divisor, sign, quotient, remainder, overflow.
  localparam int ND = 6;
  localparam logic [15:0] D_A [ND] = '{16'd100, 16'hFFF9, 16'h0007, 16'h8000, 16'h8000, 16'h0005};
  localparam logic [15:0] D_B [ND] = '{16'd7,   16'h0002, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0009};
  localparam logic        D_S [ND] = '{1'b0,    1'b1,     1'b1,     1'b1,     1'b0,     1'b0};
  localparam logic [15:0] D_Q [ND] = '{16'd14,  16'hFFFD, 16'hFFFD, 16'h8000, 16'h0000, 16'h0000};
  localparam logic [15:0] D_R [ND] = '{16'd2,   16'hFFFF, 16'h0001, 16'h0000, 16'h8000, 16'h0005};
  localparam logic        D_V [ND] = '{1'b0,    1'b0,     1'b0,     1'b1,     1'b0,     1'b0};

  // Reference: plain integer division; expected latency counted in edges after accept.
  task automatic ref_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov, output int lat);
    int sa, sb, ma, mb;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    dz  = (b == 16'h0000);
    ov  = s && (a == 16'h8000) && (b == 16'hFFFF);
    lat = 17;
    if (dz) begin
      q = 16'hFFFF;
      r = a;
      lat = 2;
    end else begin
      q = 16'(sa / sb);
      r = 16'(sa % sb);
`ifdef DIV_EARLY_EXIT_EN
      if (ma < mb) lat = 2;
`endif
    end
    if (ma < 0 || mb < 0) lat = -100; // never reached: magnitudes of 16-bit values
  endtask

  // Wait for done after an accepted start; count busy-protocol violations.
  task automatic wait_done(output int lat, output int bb);
    lat = -1;
    bb  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        if (busy !== 1'b0) bb++;
        break;
      end
      if (busy !== 1'b1) bb++;
    end
  endtask

  // Issue one operation after a one-cycle idle gap and wait for its done.
  task automatic issue_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output int lat, output int bb);
    @(posedge clk); #1;
    dividend = a; divisor = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bb);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sign = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
    #12;
    n_tests++;
    if ({busy, done, div_by_zero, overF} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, done, div_by_zero, overF});
    end
    n_tests++;
    if ({quotient, remainder} !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_results got %h/%h want 0000/0000", quotient, remainder);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] eq, er; logic edz, eov; int elat, lat, bb;
    for (int i = 0; i < ND; i++) begin
      ref_div(D_A[i], D_B[i], D_S[i], eq, er, edz, eov, elat);
      issue_op(D_A[i], D_B[i], D_S[i], lat, bb);
      n_tests++;
      if (lat !== elat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat); end
      n_tests++;
      if (quotient !== D_Q[i]) begin n_fail++; $display("FAIL dir%0d_quotient got %h want %h", i, quotient, D_Q[i]); end
      n_tests++;
      if (remainder !== D_R[i]) begin n_fail++; $display("FAIL dir%0d_remainder got %h want %h", i, remainder, D_R[i]); end
      n_tests++;
      if ({div_by_zero, overF} !== {1'b0, D_V[i]}) begin
        n_fail++; $display("FAIL dir%0d_flags got %b%b want 0%b", i, div_by_zero, overF, D_V[i]);
      end
      n_tests++;
      if (bb !== 0) begin n_fail++; $display("FAIL dir%0d_busy got %0d bad cycles want 0", i, bb); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bb;
    issue_op(16'h1234, 16'h0000, 1'b0, lat, bb);
    n_tests++;
    if ({lat, bb} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL dz_u_timing got lat %0d busybad %0d want 2 0", lat, bb); end
    n_tests++;
    if ({quotient, remainder, div_by_zero, overF} !== {16'hFFFF, 16'h1234, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL dz_u_result got %h %h %b%b want ffff 1234 10", quotient, remainder, div_by_zero, overF);
    end
    issue_op(16'h8765, 16'h0000, 1'b1, lat, bb);
    n_tests++;
    if ({lat, quotient, remainder, div_by_zero} !== {32'd2, 16'hFFFF, 16'h8765, 1'b1}) begin
      n_fail++; $display("FAIL dz_s_result got lat %0d %h %h %b want 2 ffff 8765 1", lat, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    dividend = 16'd10; divisor = 16'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
    wait_done(lat, bb);
    n_tests++;
    if ({lat, quotient, remainder} !== {32'd17, 16'd3, 16'd1}) begin
      n_fail++; $display("FAIL dz_next got lat %0d %h %h want 17 0003 0001", lat, quotient, remainder);
    end
  endtask

  task automatic test_start_during_run();
    int lat, bb;
    @(posedge clk); #1;
    dividend = 16'd1000; divisor = 16'd13; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 16'd7; divisor = 16'd0; sign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bb);
    n_tests++;
    if (lat + 5 !== 17) begin n_fail++; $display("FAIL busy_start_latency got %0d want 17", lat + 5); end
    n_tests++;
    if ({quotient, remainder, div_by_zero, bb} !== {16'd76, 16'd12, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL busy_start_result got %0d %0d dz %b busybad %0d want 76 12 0 0", quotient, remainder, div_by_zero, bb);
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    @(posedge clk); #1;
    dividend = 16'd5000; divisor = 16'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, div_by_zero, overF, quotient, remainder} !== 36'h0) begin
      n_fail++; $display("FAIL midrun_reset got %b%b%b%b %h %h want 0000 0000 0000", busy, done, div_by_zero, overF, quotient, remainder);
    end
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrun_no_done got activity %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    issue_op(16'hFFFF, 16'h0001, 1'b0, lat, bb);
    n_tests++;
    if ({lat, quotient, remainder} !== {32'd17, 16'hFFFF, 16'h0000}) begin
      n_fail++; $display("FAIL b2b_first got lat %0d %h %h want 17 ffff 0000", lat, quotient, remainder);
    end
    dividend = 16'd9; divisor = 16'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_on_done got busy %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b want 1", busy); end
    wait_done(lat, bb);
    n_tests++;
    if ({lat, quotient, remainder, bb} !== {32'd17, 16'd3, 16'd0, 32'd0}) begin
      n_fail++; $display("FAIL b2b_second got lat %0d %h %h busybad %0d want 17 0003 0000 0", lat, quotient, remainder, bb);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, eq, er; logic s, edz, eov; int elat, lat, bb, sel;
    for (int i = 0; i < 60; i++) begin
      a   = 16'($urandom);
      s   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        2, 3:    b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      if (i % 8 == 0) a = 16'h8000;
      ref_div(a, b, s, eq, er, edz, eov, elat);
      issue_op(a, b, s, lat, bb);
      n_tests++;
      if ({lat, bb} !== {elat, 32'd0}) begin
        n_fail++; $display("FAIL rnd%0d_timing %h/%h s%b got lat %0d busybad %0d want %0d 0", i, a, b, s, lat, bb, elat);
      end
      n_tests++;
      if ({quotient, remainder, div_by_zero, overF} !== {eq, er, edz, eov}) begin
        n_fail++; $display("FAIL rnd%0d_result %h/%h s%b got %h %h %b%b want %h %h %b%b",
                           i, a, b, s, quotient, remainder, div_by_zero, overF, eq, er, edz, eov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
